door_ctrl_timed: RTL and testbench



---
 rtl/door_ctrl_timed_if.sv | 28 ++
 rtl/door_ctrl_timed.sv | 167 ++++++++++++++++
 tb/tb_door_ctrl_timed.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/door_ctrl_timed_if.sv
// Signal bundle between the car controller / cabin panel and the door controller.
// The master drives requests and sensors; the slave (door_ctrl_timed) drives motor and status.
interface door_ctrl_timed_if;
    logic       calls;
    logic       alarm;
    logic       open_req;
    logic       open_btn;
    logic       close_btn;
    logic       obstruction;
    logic       at_floor;
    logic       door;
    logic [1:0] door_state;
    logic       motor_open;
    logic       motor_close;
    logic       door_locked;
    logic       door_fault;
    logic       nudge;

    modport master (
        output calls, alarm, open_req, open_btn, close_btn, obstruction, at_floor,
        input  door, door_state, motor_open, motor_close, door_locked, door_fault, nudge
    );

    modport slave (
        input  calls, alarm, open_req, open_btn, close_btn, obstruction, at_floor,
        output door, door_state, motor_open, motor_close, door_locked, door_fault, nudge
    );
endinterface

// File: rtl/door_ctrl_timed.sv
// Elevator door FSM (OPEN/CLOSING/CLOSED/OPENING) with dwell and travel timers and reversal counting.
// Define DOOR_NUDGE_EN to replace the reversal fault with a slow forced close (nudge).
module door_ctrl_timed #(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned MOVE_CYCLES  = 4,
    parameter int unsigned MAX_REOPEN   = 3,
    parameter int unsigned CNT_W        = 8
) (
    input logic              clk,
    input logic              reset,
    door_ctrl_timed_if.slave bus
);

    typedef enum logic [1:0] {
        StOpen    = 2'd0,
        StClosing = 2'd1,
        StClosed  = 2'd2,
        StOpening = 2'd3
    } state_e;

    localparam int unsigned      RW        = $clog2(MAX_REOPEN + 1);
    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] MoveLast  = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [RW-1:0]    ReopenMax = RW'(MAX_REOPEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RW-1:0]    reopen_q, reopen_d;
    logic             abort;
    logic             reverse_req;
    logic             close_done;
    logic             reversal;
    logic             enter_closed;

    // Any of these holds the door open, restarts dwell, and normally reverses a close.
    assign abort = bus.alarm | bus.obstruction | bus.open_btn;

`ifdef DOOR_NUDGE_EN
    localparam logic [CNT_W-1:0] NudgeLast = CNT_W'(2 * MOVE_CYCLES - 1);

    logic nudge_q, nudge_d;

    // A nudge close only yields to the alarm and travels at half speed.
    assign reverse_req = nudge_q ? bus.alarm : abort;
    assign close_done  = (timer_q == (nudge_q ? NudgeLast : MoveLast));
`else
    logic fault_q, fault_d;

    assign reverse_req = abort;
    assign close_done  = (timer_q == MoveLast);
`endif

    always_comb begin
        state_d  = state_q;
        reversal = 1'b0;
        unique case (state_q)
            StOpen: begin
                if (bus.calls && !abort && (timer_q >= DwellLast || bus.close_btn)) begin
                    state_d = StClosing;
                end
            end
            StClosing: begin
                if (reverse_req) begin
                    state_d  = StOpening;
                    reversal = 1'b1;
                end else if (close_done) begin
                    state_d = StClosed;
                end
            end
            StClosed: begin
                if (bus.at_floor && (bus.open_req || bus.open_btn || bus.alarm)) begin
                    state_d = StOpening;
                end
            end
            StOpening: begin
                if (timer_q == MoveLast) begin
                    state_d = StOpen;
                end
            end
        endcase
    end

    assign enter_closed = (state_d == StClosed) && (state_q != StClosed);

    always_comb begin
        reopen_d = reopen_q;
        if (reversal && (reopen_q != ReopenMax)) begin
            reopen_d = reopen_q + 1'b1;
        end
        if (enter_closed) begin
            reopen_d = '0;
        end
    end

    always_comb begin
        if ((state_d != state_q) || (state_q == StOpen && abort)) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

`ifdef DOOR_NUDGE_EN
    always_comb begin
        nudge_d = nudge_q;
        if (state_q == StOpen && state_d == StClosing) begin
            nudge_d = (reopen_q == ReopenMax);
        end else if (state_d != StClosing) begin
            nudge_d = 1'b0;
        end
    end
`else
    always_comb begin
        fault_d = fault_q;
        if (reversal && (reopen_d == ReopenMax)) begin
            fault_d = 1'b1;
        end
        if (enter_closed) begin
            fault_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StOpen;
            timer_q  <= '0;
            reopen_q <= '0;
`ifdef DOOR_NUDGE_EN
            nudge_q  <= 1'b0;
`else
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            reopen_q <= reopen_d;
`ifdef DOOR_NUDGE_EN
            nudge_q  <= nudge_d;
`else
            fault_q  <= fault_d;
`endif
        end
    end

    assign bus.door        = (state_q == StClosed);
    assign bus.door_state  = state_q;
    assign bus.motor_open  = (state_q == StOpening);
    assign bus.motor_close = (state_q == StClosing);
    assign bus.door_locked = (state_q == StClosed);
`ifdef DOOR_NUDGE_EN
    assign bus.door_fault  = 1'b0;
    assign bus.nudge       = nudge_q;
`else
    assign bus.door_fault  = fault_q;
    assign bus.nudge       = 1'b0;
`endif

    // The car must never be released while a fault is flagged, and nudge implies a close drive.
    a_lock_no_fault: assert property (@(posedge clk) disable iff (!reset)
        bus.door_locked |-> !bus.door_fault);
    a_nudge_closing: assert property (@(posedge clk) disable iff (!reset)
        bus.nudge |-> bus.motor_close);

endmodule

// File: tb/tb_door_ctrl_timed.sv
// Self-checking bench for door_ctrl_timed: vector table plus hand-written corner sequences,
// expected outputs queued at drive time and popped after each rising edge.
module tb_door_ctrl_timed;

    // Stimulus bits: {reset, calls, alarm, open_req, open_btn, close_btn, obstruction, at_floor}
    localparam logic [7:0] RUN  = 8'h80;
    localparam logic [7:0] CALL = 8'h40;
    localparam logic [7:0] ALM  = 8'h20;
    localparam logic [7:0] OREQ = 8'h10;
    localparam logic [7:0] OBTN = 8'h08;
    localparam logic [7:0] CBTN = 8'h04;
    localparam logic [7:0] OBS  = 8'h02;
    localparam logic [7:0] FLR  = 8'h01;

    localparam logic [1:0] SO = 2'd0;
    localparam logic [1:0] SC = 2'd1;
    localparam logic [1:0] SD = 2'd2;
    localparam logic [1:0] SP = 2'd3;

`ifdef DOOR_NUDGE_EN
    localparam bit F = 1'b0;
    localparam bit N = 1'b1;
`else
    localparam bit F = 1'b1;
    localparam bit N = 1'b0;
`endif

    typedef struct {
        logic [7:0]  in;
        int unsigned reps;
        logic [7:0]  exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] exp_q[$];
    vec_t       vecs[$];
    int         n_checks;
    int         n_fail;

    door_ctrl_timed_if bus ();

    door_ctrl_timed #(
        .DWELL_CYCLES(8),
        .MOVE_CYCLES (4),
        .MAX_REOPEN  (3),
        .CNT_W       (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {door, door_state, motor_open, motor_close, door_locked, door_fault, nudge}
    function automatic logic [7:0] ex(input logic [1:0] st, input bit f = 1'b0, input bit n = 1'b0);
        return {st == SD, st, st == SP, st == SC, st == SD, f, n};
    endfunction

    function automatic logic [7:0] observe();
        return {bus.door, bus.door_state, bus.motor_open, bus.motor_close, bus.door_locked,
                bus.door_fault, bus.nudge};
    endfunction

    task automatic add(input logic [7:0] v, input int unsigned r, input logic [7:0] e);
        vec_t t;
        t.in   = v;
        t.reps = r;
        t.exp  = e;
        vecs.push_back(t);
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] e, input string tag, input int idx);
        logic [7:0] got;
        logic [7:0] want;
        @(negedge clk);
        reset           = v[7];
        bus.calls       = v[6];
        bus.alarm       = v[5];
        bus.open_req    = v[4];
        bus.open_btn    = v[3];
        bus.close_btn   = v[2];
        bus.obstruction = v[1];
        bus.at_floor    = v[0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = observe();
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got %b want %b (door,state,mo,mc,lock,fault,nudge)",
                     tag, idx, $time, got, want);
        end
    endtask

    task automatic rep(input logic [7:0] v, input int n, input logic [1:0] st, input string tag);
        for (int k = 0; k < n; k++) step(v, ex(st), tag, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        bus.calls       = 1'b0;
        bus.alarm       = 1'b0;
        bus.open_req    = 1'b0;
        bus.open_btn    = 1'b0;
        bus.close_btn   = 1'b0;
        bus.obstruction = 1'b0;
        bus.at_floor    = 1'b0;

        // Reset, then the default auto-close cycle: 8 cycles OPEN, 4 CLOSING, CLOSED.
        add(8'h00, 2, ex(SO));
        add(RUN | CALL, 7, ex(SO));
        add(RUN | CALL, 4, ex(SC));
        add(RUN | CALL, 2, ex(SD));
        // Floor interlock, then reopen.
        add(RUN | CALL | OBTN, 3, ex(SD));
        add(RUN | CALL | OBTN | FLR, 1, ex(SP));
        add(RUN | CALL | FLR, 3, ex(SP));
        add(RUN | CALL, 1, ex(SO));
        // close_btn at dwell timer 1.
        add(RUN | CALL, 1, ex(SO));
        add(RUN | CALL | CBTN, 1, ex(SC));
        add(RUN | CALL, 3, ex(SC));
        add(RUN | CALL, 1, ex(SD));
        // Reversal 1: obstruction at CLOSING timer 2; dwell restarts afterwards.
        add(RUN | CALL | OREQ | FLR, 1, ex(SP));
        add(RUN | CALL, 3, ex(SP));
        add(RUN | CALL, 8, ex(SO));
        add(RUN | CALL, 3, ex(SC));
        add(RUN | CALL | OBS, 1, ex(SP));
        add(RUN | CALL, 3, ex(SP));
        add(RUN | CALL, 8, ex(SO));
        add(RUN | CALL, 1, ex(SC));
        // Reversal 2.
        add(RUN | CALL | OBS, 1, ex(SP));
        add(RUN | CALL, 3, ex(SP));
        add(RUN | CALL, 1, ex(SO));
        add(RUN | CALL | CBTN, 1, ex(SC));
        // Reversal 3 reaches the limit.
        add(RUN | CALL | OBS, 1, ex(SP, F, 1'b0));
        add(RUN | CALL, 3, ex(SP, F, 1'b0));
        add(RUN | CALL, 1, ex(SO, F, 1'b0));
        add(RUN | CALL | CBTN, 1, ex(SC, F, N));
`ifdef DOOR_NUDGE_EN
        add(RUN | CALL | OBS | OBTN, 7, ex(SC, 1'b0, 1'b1));
        add(RUN | CALL | OBS | OBTN, 1, ex(SD));
`else
        add(RUN | CALL, 3, ex(SC, 1'b1, 1'b0));
        add(RUN | CALL, 1, ex(SD));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < int'(vecs[i].reps); r++) step(vecs[i].in, vecs[i].exp, "vec", i);
        end

        // Reset in mid-close overrides everything.
        rep(RUN | CALL | OREQ | FLR, 1, SP, "reopen");
        rep(RUN | CALL, 3, SP, "opening");
        rep(RUN | CALL, 1, SO, "open");
        rep(RUN | CALL | CBTN, 1, SC, "close_btn");
        rep(RUN | CALL, 2, SC, "closing_t2");
        rep(CALL | OBS | CBTN | ALM, 1, SO, "reset_mid_close");
        rep(RUN | CALL, 7, SO, "post_reset_dwell");
        // Obstruction coincident with travel completion reverses.
        rep(RUN | CALL, 4, SC, "closing_t3");
        rep(RUN | CALL | OBS, 1, SP, "reverse_beats_done");
        rep(RUN | CALL, 3, SP, "opening");
        rep(RUN | CALL, 1, SO, "open");
        // Alarm holds OPEN, restarts dwell, and reverses a close.
        rep(RUN | CALL | ALM, 10, SO, "alarm_hold");
        rep(RUN | CALL, 7, SO, "alarm_dwell");
        rep(RUN | CALL, 1, SC, "closing");
        rep(RUN | CALL | ALM, 1, SP, "alarm_reverse");
        rep(RUN | CALL, 3, SP, "opening");
        rep(RUN | CALL, 1, SO, "open");
        // No calls: OPEN forever, close_btn alone does nothing; timer saturates instead of wrapping.
        rep(RUN, 258, SO, "no_calls");
        rep(RUN | CBTN, 2, SO, "cbtn_no_calls");
        rep(RUN | CALL, 1, SC, "timer_saturated");
        rep(RUN | CALL, 3, SC, "closing");
        rep(RUN | CALL, 1, SD, "closed");
        // Alarm in CLOSED only opens at a floor.
        rep(RUN | ALM, 2, SD, "alarm_off_floor");
        rep(RUN | ALM | FLR, 1, SP, "alarm_at_floor");
        rep(RUN, 3, SP, "opening");
        rep(RUN, 1, SO, "open");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
